// File: rtl/pkt_capture_pkg.sv
// pkt_capture_pkg: shared states and constants for the capture tap
package pkt_capture_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, TRUNC, DROP, HANDOFF} cap_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W = 32;
  localparam logic [LEN_W-1:0] SNAP_ZERO_LEN = 32'd65535;
endpackage

// File: rtl/pkt_fifo.sv
// pkt_fifo: show-ahead single-clock FIFO with commit and rewind of a pending packet
module pkt_fifo #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [31:0]              wdata,
  input  logic                     commit,
  input  logic                     rewind,
  input  logic                     rd,
  output logic [31:0]              rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, base;
  // rewind restarts writing at the commit point; commit publishes everything written so far
  always_comb begin
    base  = rewind ? cm_q : wr_q;
    wr_d  = base + {{AW{1'b0}}, wr};
    cm_d  = commit ? wr_d : cm_q;
    cnt   = cm_q - rd_q;
    full  = (wr_q - rd_q) == FULL_CNT;
    rd_d  = rd_q + {{AW{1'b0}}, rd && (cnt != '0)};
    rdata = mem[rd_q[AW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
    end
  end
  // storage array, written at the rewound or current write position
  always_ff @(posedge clk) begin
    if (wr) mem[base[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/pkt_capture.sv
// pkt_capture: ingress tap truncating packets to snaplen into a commit/rewind FIFO
module pkt_capture
  import pkt_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned AE_LEVEL   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] snaplen,
  input  logic        snk_valid,
  input  logic [31:0] snk_data,
  input  logic        snk_sop,
  input  logic        snk_eop,
  input  logic [1:0]  snk_empty,
  input  logic        fifo_rd,
  output logic [31:0] fifo_out,
  output logic        almost_empty,
  output logic        wr_ctrl,
  output logic [31:0] pkt_len,
  output logic [31:0] orig_len,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  cap_state_t state_q, state_d;
  logic [LEN_W-1:0] acc_q, acc_d, pkt_len_q, pkt_len_d, orig_len_q, orig_len_d;
  logic [LEN_W-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [LEN_W-1:0] snap, base, nbytes, sum, orig_nx;
  logic hmid_q, hmid_d;
  logic in_pkt, can_start, sop_v, restart, start, active, want, ovf, wr, done, rewind, fifo_full;
  logic [AW:0] fifo_cnt;
  pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr(wr), .wdata(snk_data), .commit(done), .rewind(rewind),
    .rd(fifo_rd), .rdata(fifo_out), .full(fifo_full), .cnt(fifo_cnt)
  );
  assign almost_empty = 32'(fifo_cnt) <= AE_LEVEL;
  assign wr_ctrl      = state_q == HANDOFF;
  assign pkt_len      = pkt_len_q;
  assign orig_len     = orig_len_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  // beat classification, length accounting and next state
  always_comb begin
    snap       = (snaplen == '0) ? SNAP_ZERO_LEN : LEN_W'(snaplen);
    in_pkt     = (state_q == CAPTURE) || (state_q == TRUNC);
    can_start  = in_pkt || (state_q == IDLE) || (state_q == DROP);
    sop_v      = snk_valid && snk_sop;
    restart    = in_pkt && sop_v;
    start      = can_start && sop_v && enable;
    active     = start || (in_pkt && snk_valid && !snk_sop);
    base       = start ? '0 : acc_q;
    nbytes     = snk_eop ? LEN_W'(BYTES_PER_WORD) - LEN_W'(snk_empty) : LEN_W'(BYTES_PER_WORD);
    sum        = base + nbytes;
    orig_nx    = (sum < base) ? '1 : sum;
    want       = active && !(state_q == TRUNC && !start) && (base < snap);
    ovf        = want && (restart ? (fifo_cnt == FULL_CNT) : fifo_full);
    wr         = want && !ovf;
    done       = active && snk_eop && !ovf;
    rewind     = restart || ovf;
    hmid_d     = (state_q == HANDOFF) && (snk_valid ? (sop_v || hmid_q) && !snk_eop : hmid_q);
    acc_d      = active ? orig_nx : acc_q;
    pkt_len_d  = done ? ((orig_nx < snap) ? orig_nx : snap) : pkt_len_q;
    orig_len_d = done ? orig_nx : orig_len_q;
    pkt_cnt_d  = pkt_cnt_q + LEN_W'(done);
    drop_cnt_d = drop_cnt_q + LEN_W'(restart) + LEN_W'(ovf) + LEN_W'(state_q == HANDOFF && sop_v);
    state_d    = state_q;
    if (active)
      state_d = ovf ? (snk_eop ? IDLE : DROP) : done ? HANDOFF : (orig_nx >= snap) ? TRUNC : CAPTURE;
    else if (can_start && sop_v)
      state_d = snk_eop ? IDLE : DROP;
    else if (state_q == DROP && snk_valid && snk_eop)
      state_d = IDLE;
    else if (state_q == HANDOFF && wr_ctrl_rdy)
      state_d = hmid_d ? DROP : IDLE;
  end
  // state, length and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pkt_len_q  <= '0;
      orig_len_q <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      hmid_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pkt_len_q  <= pkt_len_d;
      orig_len_q <= orig_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      hmid_q     <= hmid_d;
    end
  end
endmodule

// File: doc/pkt_capture.md
# pkt_capture

Ingress packet tap for the capture path. Accepts a 32-bit Avalon-ST style beat stream from the MAC side with no backpressure, truncates each packet to a run-time snap length, and buffers its words in an internal packet FIFO. The FIFO supports commit and rewind, so an overflowing or aborted packet leaves nothing behind. On each committed packet it raises `wr_ctrl` with `pkt_len` and `orig_len`; it then holds off new captures until the downstream write controller returns `wr_ctrl_rdy`. It sits directly upstream of the write controller and drives that block's `fifo_out`, `almost_empty`, `wr_ctrl` and `pkt_len` inputs.

## Interface
- `FIFO_DEPTH`, 512: FIFO depth in 32-bit words; power of two, at least 4.
- `AE_LEVEL`, 0: `almost_empty` is asserted while committed word count <= `AE_LEVEL`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: capture enable, sampled at start of packet.
- `snaplen` in 16: maximum captured bytes per packet; 0 is treated as 65535.
- `snk_valid` in 1: beat valid; there is no ready signal.
- `snk_data` in 32: beat data; byte 0 is in [31:24].
- `snk_sop` in 1: first beat of packet.
- `snk_eop` in 1: last beat of packet.
- `snk_empty` in 2: unused bytes in the eop beat; ignored otherwise.
- `fifo_rd` in 1: pop the head word; ignored while the committed count is 0.
- `fifo_out` out 32: head committed word (show-ahead).
- `almost_empty` out 1: committed-level flag.
- `wr_ctrl` out 1: descriptor available (level).
- `pkt_len` out 32: captured bytes, equal to min(orig_len, snaplen).
- `orig_len` out 32: on-wire bytes of the packet.
- `wr_ctrl_rdy` in 1: downstream finished with the current packet.
- `pkt_cnt` out 32: committed packets.
- `drop_cnt` out 32: dropped or aborted packets.

## Operation
- States are `IDLE`, `CAPTURE`, `TRUNC`, `DROP`, `HANDOFF`.
- `IDLE`: a beat with `snk_valid && snk_sop && enable` starts a packet, and that beat itself is processed as a `CAPTURE` beat. A `sop` seen while `enable` is 0 moves to `DROP` and does not count. Beats without `sop` are ignored.
- `CAPTURE`: each beat adds 4 bytes to `orig_len`, or 4−`snk_empty` bytes on eop. The word is written if the captured byte count before the beat is < snaplen. Once the captured count reaches snaplen, go to `TRUNC`.
- `TRUNC`: count `orig_len` only; no writes.
- On eop in `CAPTURE` or `TRUNC`:
  - commit the FIFO write pointer;
  - latch `pkt_len` = min(orig_len, snaplen) and `orig_len`;
  - increment `pkt_cnt`;
  - go to `HANDOFF`.
- A write attempted while the FIFO (committed plus uncommitted words) is full:
  - rewind the write pointer to the packet start;
  - increment `drop_cnt`;
  - go to `DROP`.
- `sop` while in `CAPTURE` or `TRUNC` (missing eop):
  - rewind;
  - increment `drop_cnt`;
  - start the new packet on that same beat.
- `DROP`: discard beats until eop, then go to `IDLE`. A `sop` in `DROP` starts a fresh packet as in `IDLE`.
- `HANDOFF`: hold `wr_ctrl`=1; `pkt_len` and `orig_len` are stable. When `wr_ctrl_rdy`=1, clear `wr_ctrl` and go to `IDLE`.
  - A `sop` arriving in `HANDOFF` is dropped: `drop_cnt`+1, go to `DROP` once `wr_ctrl_rdy` arrives, or discard the beats in place.
  - Exactly one descriptor is outstanding.
- Deasserting `enable` mid-packet does not abort that packet.
- Byte counters are 32-bit. `orig_len` saturates at 0xFFFF_FFFF.
- The snaplen comparison is done at 32 bits with snaplen zero-extended.

## Timing
- Reset values:
  - `wr_ctrl`=0; `pkt_len`=0; `orig_len`=0; `pkt_cnt`=0; `drop_cnt`=0;
  - `almost_empty`=1; FIFO pointers 0; state `IDLE`;
  - `fifo_out` is don't-care while empty.
- Reset mid-packet or mid-handoff discards all FIFO contents.
- Write latency: a word written on edge N is not readable until it is committed.
- Commit happens on the eop edge. `almost_empty` and `fifo_out` reflect the committed words in the cycle after that edge.
- `wr_ctrl` rises in the cycle after the eop beat, at the same time the words become visible.
- `fifo_rd` pops on the edge; the next word appears on `fifo_out` the cycle after that edge.
- A simultaneous `fifo_rd` and write is allowed. Full is evaluated before the pop, so a write to a full FIFO drops even if a pop occurs on that same edge.
- Rewind and commit never coincide. Rewind takes effect on its edge, and the aborted words are never readable.
- A `wr_ctrl_rdy` pulse of 1 cycle suffices. `wr_ctrl_rdy` outside `HANDOFF` is ignored.

## Structure
- Package `pkt_capture_pkg` holds:
  - the state enum `cap_state_t`;
  - `BYTES_PER_WORD`=4;
  - `LEN_W`=32;
  - the snaplen-zero substitute constant.
- Sub-module `pkt_fifo` is a single-clock, show-ahead RAM FIFO. It has separate `wr_ptr`, `commit_ptr` and `rd_ptr`, `commit` and `rewind` strobes, and `full` and committed-count outputs.
- The top level contains the FSM, the length counters and the statistics counters.

## Test plan
- 64-byte packet (16 beats, `snk_empty`=0), `snaplen`=100 -> `wr_ctrl` rises 1 cycle after eop; `pkt_len`=`orig_len`=64; 16 words read back in order; `pkt_cnt`=1.
- 61-byte packet (16 beats, `snk_empty`=3), `snaplen`=32 -> 8 words stored; `pkt_len`=32; `orig_len`=61.
- `FIFO_DEPTH`=16, 20-beat packet -> `drop_cnt`=1; committed count 0; `almost_empty`=1; no `wr_ctrl`; the next 8-beat packet is captured correctly.
- Packet A starts with sop and is hit by a second sop at beat 5 with no eop -> A rewound, `drop_cnt`=1; B captured alone, `pkt_len`=B's length.
- Second packet arrives while in `HANDOFF` with `wr_ctrl_rdy` held low -> that packet is dropped, `drop_cnt`=1; the first descriptor's values are unchanged.
- `reset` asserted at beat 3 of a packet and during `HANDOFF` -> all outputs at their reset values the next cycle; a following 4-beat packet gives `pkt_len`=16.
